// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, halfword-indexed instruction cache with a byte-stream miss fill
module instr_cache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        need_flush_in,
    input  logic        fetch_enable_in,
    input  logic [31:0] pc_in,
    output logic        ic_hit,
    output logic        ic_miss_ready,
    output logic [31:0] ic_instr,
    output logic        ic2mc_req,
    output logic [31:0] ic2mc_addr,
    input  logic        mc2ic_valid,
    input  logic [7:0]  mc2ic_byte
);
    localparam int N  = 1 << INDEX_WIDTH;
    localparam int TW = 31 - INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      valid_q, valid_d;
    logic [TW-1:0]     tag_q [N];
    logic [31:0]       data_q [N];
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic              mr_q, mr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       buf_q, buf_d;
    logic              wr;
    logic              last;
    logic [31:0]       fill_word;
    logic [INDEX_WIDTH-1:0] idx, fidx;

    assign idx  = pc_in[INDEX_WIDTH:1];
    assign fidx = addr_q[INDEX_WIDTH:1];

    assign ic_hit = state_q == IDLE && fetch_enable_in && valid_q[idx] &&
                    tag_q[idx] == pc_in[31:INDEX_WIDTH+1] && !need_flush_in;
    assign ic_instr      = mr_q ? buf_q : data_q[idx];
    assign ic_miss_ready = mr_q;
    assign ic2mc_req     = req_q;
    assign ic2mc_addr    = addr_q;

    // An RVC instruction is recognised from its first byte, so it ends after byte 2
    assign last      = (cnt_q == 2'd1 && buf_q[1:0] != 2'b11) || cnt_q == 2'd3;
    assign fill_word = cnt_q == 2'd1 ? {16'b0, mc2ic_byte, buf_q[7:0]} : {mc2ic_byte, buf_q[23:0]};

    // Next-state: miss detection, byte collection, entry write and flush abort
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        mr_d    = 1'b0;
        wr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_enable_in && !ic_hit && !need_flush_in) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_in;
                    cnt_d   = 2'd0;
                end
            end
            FETCH: begin
                if (need_flush_in) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    cnt_d   = 2'd0;
                end else if (mc2ic_valid && req_q) begin
                    cnt_d = cnt_q + 2'd1;
                    if (last) begin
                        state_d       = DONE;
                        req_d         = 1'b0;
                        buf_d         = fill_word;
                        mr_d          = 1'b1;
                        wr            = 1'b1;
                        valid_d[fidx] = 1'b1;
                    end else begin
                        buf_d[{cnt_q, 3'b000} +: 8] = mc2ic_byte;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and fill registers; everything holds while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            valid_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            mr_q    <= 1'b0;
            cnt_q   <= 2'd0;
            buf_q   <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            mr_q    <= mr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Tag and data arrays are not reset; valid bits guard them
    always_ff @(posedge clk_in) begin
        if (rdy_in && wr) begin
            tag_q[fidx]  <= addr_q[31:INDEX_WIDTH+1];
            data_q[fidx] <= fill_word;
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed stimulus with a per-entry cache model checked every cycle
module tb_instr_cache;
    localparam int IW = 6;
    localparam int N  = 1 << IW;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        need_flush_in = 1'b0;
    logic        fetch_enable_in = 1'b0;
    logic [31:0] pc_in = '0;
    logic        mc2ic_valid = 1'b0;
    logic [7:0]  mc2ic_byte = '0;
    logic        ic_hit, ic_miss_ready, ic2mc_req;
    logic [31:0] ic_instr, ic2mc_addr;

    int errors = 0;
    int checks = 0;

    bit          m_v   [N];
    logic [31:0] m_pc  [N];
    logic [31:0] m_ins [N];

    instr_cache #(.INDEX_WIDTH(IW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
        .fetch_enable_in(fetch_enable_in), .pc_in(pc_in), .ic_hit(ic_hit),
        .ic_miss_ready(ic_miss_ready), .ic_instr(ic_instr), .ic2mc_req(ic2mc_req),
        .ic2mc_addr(ic2mc_addr), .mc2ic_valid(mc2ic_valid), .mc2ic_byte(mc2ic_byte)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int ix(input logic [31:0] pc);
        return int'(pc[IW:1]);
    endfunction

    // Instruction held for a 4-byte little-endian stream w: RVC keeps only the low half
    function automatic logic [31:0] model_ins(input logic [31:0] w);
        return (w[1:0] != 2'b11) ? {16'b0, w[15:0]} : w;
    endfunction

    always @(negedge clk_in) begin
        int  i;
        bit  eh;
        i  = ix(pc_in);
        eh = rst_in && fetch_enable_in && !need_flush_in && m_v[i] && m_pc[i] == pc_in;
        chk("cmp_hit", {31'b0, ic_hit}, {31'b0, eh});
        if (eh) chk("cmp_instr", ic_instr, m_ins[i]);
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_model;
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    endtask

    task automatic miss(input logic [31:0] pc, input logic [31:0] w, input int stall_at);
        int          nb;
        logic [31:0] e;
        nb = (w[1:0] != 2'b11) ? 2 : 4;
        e  = model_ins(w);
        fetch_enable_in = 1'b1;
        pc_in = pc;
        #1;
        chk("miss_hit", {31'b0, ic_hit}, 32'd0);
        chk("miss_req_pre", {31'b0, ic2mc_req}, 32'd0);
        tick;
        fetch_enable_in = 1'b0;
        #1;
        chk("req_rise", {31'b0, ic2mc_req}, 32'd1);
        chk("req_addr", ic2mc_addr, pc);
        tick;
        for (int k = 0; k < nb; k++) begin
            if (k == stall_at) begin
                rdy_in = 1'b0;
                mc2ic_valid = 1'b1;
                mc2ic_byte = 8'hFF;
                repeat (3) begin
                    #1;
                    chk("stall_req", {31'b0, ic2mc_req}, 32'd1);
                    chk("stall_addr", ic2mc_addr, pc);
                    chk("stall_mr", {31'b0, ic_miss_ready}, 32'd0);
                    tick;
                end
                rdy_in = 1'b1;
            end
            mc2ic_valid = 1'b1;
            mc2ic_byte = w[8*k +: 8];
            #1;
            chk("req_held", {31'b0, ic2mc_req}, 32'd1);
            tick;
        end
        mc2ic_byte = 8'hAA;
        #1;
        chk("req_drop", {31'b0, ic2mc_req}, 32'd0);
        chk("miss_ready", {31'b0, ic_miss_ready}, 32'd1);
        chk("fill_instr", ic_instr, e);
        m_v[ix(pc)]   = 1'b1;
        m_pc[ix(pc)]  = pc;
        m_ins[ix(pc)] = e;
        tick;
        mc2ic_valid = 1'b0;
        #1;
        chk("mr_pulse", {31'b0, ic_miss_ready}, 32'd0);
        chk("req_idle", {31'b0, ic2mc_req}, 32'd0);
        tick;
    endtask

    task automatic hit_chk(input logic [31:0] pc, input logic [31:0] exp);
        fetch_enable_in = 1'b1;
        pc_in = pc;
        #1;
        chk("hit", {31'b0, ic_hit}, 32'd1);
        chk("hit_instr", ic_instr, exp);
        tick;
        fetch_enable_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs [5];
        clear_model;
        #1;
        fetch_enable_in = 1'b1;
        #1;
        chk("rst_req", {31'b0, ic2mc_req}, 32'd0);
        chk("rst_mr", {31'b0, ic_miss_ready}, 32'd0);
        chk("rst_addr", ic2mc_addr, 32'd0);
        chk("rst_hit", {31'b0, ic_hit}, 32'd0);
        tick;
        tick;
        fetch_enable_in = 1'b0;
        rst_in = 1'b1;
        tick;

        miss(32'h0, 32'h00000513, -1);
        hit_chk(32'h0, 32'h00000513);

        miss(32'h6, 32'hDEAD4501, -1);
        hit_chk(32'h6, 32'h00004501);

        fetch_enable_in = 1'b1;
        pc_in = 32'h10;
        #1;
        chk("fl_miss", {31'b0, ic_hit}, 32'd0);
        tick;
        fetch_enable_in = 1'b0;
        #1;
        chk("fl_req", {31'b0, ic2mc_req}, 32'd1);
        tick;
        mc2ic_valid = 1'b1;
        mc2ic_byte = 8'h13;
        tick;
        mc2ic_byte = 8'h05;
        tick;
        need_flush_in = 1'b1;
        mc2ic_byte = 8'h00;
        #1;
        chk("fl_req_before", {31'b0, ic2mc_req}, 32'd1);
        tick;
        need_flush_in = 1'b0;
        mc2ic_valid = 1'b0;
        #1;
        chk("fl_req_low", {31'b0, ic2mc_req}, 32'd0);
        chk("fl_no_mr", {31'b0, ic_miss_ready}, 32'd0);
        tick;
        #1;
        chk("fl_no_mr2", {31'b0, ic_miss_ready}, 32'd0);
        tick;
        miss(32'h10, 32'h00100093, -1);
        hit_chk(32'h10, 32'h00100093);

        miss(32'h4, 32'h000002B7, -1);
        hit_chk(32'h4, 32'h000002B7);
        miss(32'h4 + (32'd2 << IW), 32'h0000A009, -1);
        hit_chk(32'h84, 32'h0000A009);
        miss(32'h4, 32'h000002B7, -1);

        miss(32'h20, 32'h00001537, 2);
        hit_chk(32'h20, 32'h00001537);

        fetch_enable_in = 1'b1;
        pc_in = 32'h30;
        tick;
        fetch_enable_in = 1'b0;
        tick;
        mc2ic_valid = 1'b1;
        mc2ic_byte = 8'h13;
        tick;
        mc2ic_valid = 1'b0;
        #1;
        chk("ar_req_before", {31'b0, ic2mc_req}, 32'd1);
        #1;
        rst_in = 1'b0;
        clear_model;
        #1;
        chk("ar_req", {31'b0, ic2mc_req}, 32'd0);
        chk("ar_mr", {31'b0, ic_miss_ready}, 32'd0);
        chk("ar_addr", ic2mc_addr, 32'd0);
        tick;
        tick;
        rst_in = 1'b1;
        tick;
        pcs[0] = 32'h0;
        pcs[1] = 32'h6;
        pcs[2] = 32'h4;
        pcs[3] = 32'h84;
        pcs[4] = 32'h20;
        for (int i = 0; i < 5; i++) begin
            fetch_enable_in = 1'b1;
            pc_in = pcs[i];
            #1;
            chk("post_rst_miss", {31'b0, ic_hit}, 32'd0);
            tick;
            fetch_enable_in = 1'b0;
            need_flush_in = 1'b1;
            tick;
            need_flush_in = 1'b0;
        end
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
